keypad_entry: RTL
=================

KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 SHALL have parameter DIGITS, default 4, BCD digits per operand (1..8).
REQ-002 SHALL have parameter OPERANDS, default 2, number of operand registers (1..8).
REQ-003 SHALL have parameter IW, default 1, width of index, equal to max(1, clog2(OPERANDS)).
REQ-004 SHALL have parameter CW, default 3, width of count, equal to clog2(DIGITS+1).
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-007 SHALL have port key  input  5  keypad decoder code: 0-9 digit, 10 NEXT, 11 BACK, 12 CLEAR, 13 ENTER, 31 idle; 14-30 reserved.
REQ-008 SHALL have port set  input  1  load request for the current operand.
REQ-009 SHALL have port set_val  input  DIGITS*4  BCD value loaded by set.
REQ-010 SHALL have port ops  output  OPERANDS*DIGITS*4  operand k at bits [k*DIGITS*4 +: DIGITS*4], digit 0 least significant.
REQ-011 SHALL have port index  output  IW  current operand number.
REQ-012 SHALL have port count  output  CW  significant digits held in the current operand.
REQ-013 SHALL have port st  output  2  state: 00 ENTRY, 01 FULL, 10 DONE.
REQ-014 SHALL have port done  output  1  one-cycle pulse on ENTER acceptance.
REQ-015 SHALL have port err  output  1  one-cycle pulse on a rejected key.

Function
REQ-016 SHALL register key every cycle as key_prev; a key event occurs when key != 31 and key_prev == 31.
REQ-017 SHALL apply an event at the edge where it is detected; outputs reflect it from the next cycle, so latency is 1 clk.
REQ-018 SHALL take no action while a key is held; the key must return to 31 before a new event.
REQ-019 Digit in ENTRY with count 0 and key 0 SHALL be ignored, with no count change and no err.
REQ-020 Any other digit in ENTRY SHALL shift the current operand left one digit, insert the key into digit 0, and increment count; if count reaches DIGITS, st becomes FULL.
REQ-021 Digit in FULL SHALL be rejected: err pulses and the operand is unchanged.
REQ-022 Digit in DONE SHALL clear all operands, set index=0 and count=0, then apply the digit as in ENTRY; st becomes ENTRY or FULL.
REQ-023 BACK with count>0 in ENTRY/FULL SHALL shift the operand right one digit, clear its top digit, decrement count, and set st to ENTRY.
REQ-024 BACK with count 0, or in DONE, SHALL pulse err with no change.
REQ-025 NEXT with index<OPERANDS-1 in ENTRY/FULL SHALL increment index, set count=0 and st ENTRY, and leave operand contents intact.
REQ-026 NEXT on the last operand, or in DONE, SHALL pulse err with no change.
REQ-027 ENTER in ENTRY/FULL SHALL set st to DONE and pulse done; index and operands are held.
REQ-028 ENTER in DONE SHALL pulse err.
REQ-029 CLEAR in any state SHALL zero all operands, set index=0, count=0 and st ENTRY, with no err.
REQ-030 Reserved codes 14-30 SHALL be ignored, with no err.
REQ-031 set=1 SHALL load set_val into the current operand, set count=DIGITS and st FULL (DONE becomes FULL); a simultaneous key event is dropped, but key_prev still updates.
REQ-032 done and err SHALL never be high in the same cycle; each lasts exactly one cycle.
REQ-033 Non-BCD digits in set_val SHALL be stored unmodified.

Reset
REQ-034 rst=0 at a clock edge SHALL set ops=0, index=0, count=0, st=00, done=0, err=0 and key_prev=31, overriding set and key.
REQ-035 A key held across reset release SHALL produce exactly one event, at the first edge with rst=1.

Verification (DIGITS=4, OPERANDS=2)
REQ-036 Keys 1,2,3,4 each followed by idle -> ops[15:0]=0x1234, count=4, st=01; a 5th digit 5 -> err pulse, value unchanged.
REQ-037 Keys 0,0,7 -> ops[15:0]=0x0007, count=1; then BACK -> 0x0000, count=0; BACK again -> err.
REQ-038 Keys 9, NEXT, 8, ENTER -> ops=0x0008_0009, index=1, st=10, done pulse; then NEXT -> err.
REQ-039 In DONE, key 5 -> ops=0x00000005, index=0, count=1, st=00.
REQ-040 set=1 with set_val=0x4321 and key 6 in the same cycle -> operand=0x4321, count=4, st=01, and the digit is not applied.
REQ-041 Key 3 held constant for 10 cycles -> exactly one shift; rst=0 mid-entry -> all outputs zero on the next cycle.

Source files
------------

// File: rtl/keypad_entry.sv
// Keypad operand entry: edge-detected key events build up to OPERANDS BCD operands
// of DIGITS digits each, with BACK/NEXT/CLEAR/ENTER editing and a parallel load path.
module keypad_entry #(
    parameter int DIGITS   = 4,
    parameter int OPERANDS = 2,
    parameter int IW       = (OPERANDS > 1) ? $clog2(OPERANDS) : 1,
    parameter int CW       = $clog2(DIGITS + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [4:0]                   key,
    input  logic                         set,
    input  logic [DIGITS*4-1:0]          set_val,
    output logic [OPERANDS*DIGITS*4-1:0] ops,
    output logic [IW-1:0]                index,
    output logic [CW-1:0]                count,
    output logic [1:0]                   st,
    output logic                         done,
    output logic                         err
);
    localparam int OW = DIGITS * 4;

    typedef enum logic [1:0] {
        S_ENTRY = 2'b00,
        S_FULL  = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    localparam logic [4:0] K_NEXT  = 5'd10;
    localparam logic [4:0] K_BACK  = 5'd11;
    localparam logic [4:0] K_CLEAR = 5'd12;
    localparam logic [4:0] K_ENTER = 5'd13;
    localparam logic [4:0] K_IDLE  = 5'd31;

    logic [OW-1:0] ops_q [OPERANDS];
    logic [OW-1:0] ops_d [OPERANDS];
    logic [IW-1:0] index_q, index_d;
    logic [CW-1:0] count_q, count_d;
    state_t        st_q, st_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [4:0]    key_prev_q;

    logic          key_ev;
    logic [OW-1:0] cur;
    logic [OW-1:0] op_v;
    logic [IW-1:0] idx_v;
    logic [CW-1:0] cnt_v;

    assign key_ev = (key != K_IDLE) && (key_prev_q == K_IDLE);
    assign cur    = ops_q[index_q];

    always_comb begin
        ops_d   = ops_q;
        index_d = index_q;
        count_d = count_q;
        st_d    = st_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        // A digit arriving in DONE starts over from a cleared operand set.
        op_v    = (st_q == S_DONE) ? '0 : cur;
        idx_v   = (st_q == S_DONE) ? '0 : index_q;
        cnt_v   = (st_q == S_DONE) ? '0 : count_q;

        if (set) begin
            ops_d[index_q] = set_val;
            count_d        = CW'(DIGITS);
            st_d           = S_FULL;
        end else if (key_ev) begin
            if (key <= 5'd9) begin
                if (st_q == S_FULL) begin
                    err_d = 1'b1;
                end else begin
                    if (st_q == S_DONE) begin
                        for (int k = 0; k < OPERANDS; k++) ops_d[k] = '0;
                        index_d = '0;
                        count_d = '0;
                        st_d    = S_ENTRY;
                    end
                    // A leading zero carries no significance and is dropped silently.
                    if (!(cnt_v == '0 && key == 5'd0)) begin
                        ops_d[idx_v] = (op_v << 4) | OW'(key[3:0]);
                        count_d      = cnt_v + CW'(1);
                        st_d         = (cnt_v + CW'(1) == CW'(DIGITS)) ? S_FULL : S_ENTRY;
                    end
                end
            end else begin
                case (key)
                    K_NEXT: begin
                        if (st_q != S_DONE && index_q < IW'(OPERANDS - 1)) begin
                            index_d = index_q + IW'(1);
                            count_d = '0;
                            st_d    = S_ENTRY;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    K_BACK: begin
                        if (st_q != S_DONE && count_q != '0) begin
                            ops_d[index_q] = cur >> 4;
                            count_d        = count_q - CW'(1);
                            st_d           = S_ENTRY;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    K_CLEAR: begin
                        for (int k = 0; k < OPERANDS; k++) ops_d[k] = '0;
                        index_d = '0;
                        count_d = '0;
                        st_d    = S_ENTRY;
                    end
                    K_ENTER: begin
                        if (st_q != S_DONE) begin
                            st_d   = S_DONE;
                            done_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < OPERANDS; k++) ops_q[k] <= '0;
            index_q    <= '0;
            count_q    <= '0;
            st_q       <= S_ENTRY;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            key_prev_q <= K_IDLE;
        end else begin
            for (int k = 0; k < OPERANDS; k++) ops_q[k] <= ops_d[k];
            index_q    <= index_d;
            count_q    <= count_d;
            st_q       <= st_d;
            done_q     <= done_d;
            err_q      <= err_d;
            key_prev_q <= key;
        end
    end

    for (genvar g = 0; g < OPERANDS; g++) begin : g_ops
        assign ops[g*OW +: OW] = ops_q[g];
    end

    assign index = index_q;
    assign count = count_q;
    assign st    = st_q;
    assign done  = done_q;
    assign err   = err_q;
endmodule
